// File: rtl/lock_sequencer.sv
// Serial code lock controller: shifts in a code LSB first, compares it against a
// programmable code, and manages the unlock pulse, failure count and lockout window.
module lock_sequencer #(
    parameter int                CODE_W         = 6,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 6'b101100,
    parameter int                MAX_FAILS      = 3,
    parameter int                UNLOCK_CYCLES  = 8,
    parameter int                LOCKOUT_CYCLES = 32,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              b_valid,
    input  logic              b_in,
    input  logic              prog_req,
    input  logic [CODE_W-1:0] prog_code,
    output logic              unlock,
    output logic              locked_out,
    output logic              attempt_fail,
    output logic              prog_ack,
    output logic              prog_nack,
    output logic [3:0]        fail_cnt,
    output logic              busy
);

    localparam int CNT_W   = $clog2(CODE_W);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int GAP_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(CODE_W - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_LIMIT   = 4'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t            state;
    logic [CODE_W-1:0] seq;
    logic [CODE_W-1:0] code_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMR_W-1:0]  tmr;
    logic [3:0]        fail_next;
    logic              bit_take;
    logic              prog_ok;

    // bit_cnt is held at zero outside an attempt, so it indexes the first bit too
    assign bit_take  = b_valid && ((state == S_IDLE) || (state == S_LOAD));
    assign prog_ok   = prog_req && (state == S_OPEN);
    assign fail_next = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (bit_take) begin
            seq[bit_cnt] <= b_in;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state        <= S_IDLE;
            code_reg     <= DEFAULT_CODE;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            tmr          <= '0;
            fail_cnt     <= '0;
            unlock       <= 1'b0;
            locked_out   <= 1'b0;
            attempt_fail <= 1'b0;
            prog_ack     <= 1'b0;
            prog_nack    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            attempt_fail <= 1'b0;
            prog_ack     <= prog_ok;
            prog_nack    <= prog_req && !prog_ok;
            if (prog_ok) begin
                code_reg <= prog_code;
            end

            case (state)
                S_IDLE: begin
                    if (b_valid) begin
                        bit_cnt <= CNT_W'(1);
                        gap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (b_valid) begin
                        gap_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= S_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        // abandoned attempt: silently dropped, not a failure
                        gap_cnt <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                S_CHECK: begin
                    busy <= 1'b0;
                    tmr  <= '0;
                    if (seq == code_reg) begin
                        unlock   <= 1'b1;
                        fail_cnt <= '0;
                        state    <= S_OPEN;
                    end else begin
                        attempt_fail <= 1'b1;
                        fail_cnt     <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            locked_out <= 1'b1;
                            state      <= S_LOCKOUT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_OPEN: begin
                    if (tmr == UNLOCK_LAST) begin
                        unlock <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                S_LOCKOUT: begin
                    if (tmr == LOCKOUT_LAST) begin
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: countdown/queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_lock_sequencer;

    localparam int         CODE_W         = 6;
    localparam logic [5:0] DEF            = 6'b101100;
    localparam logic [5:0] NEW_CODE       = 6'b010011;
    localparam int         MAX_FAILS      = 3;
    localparam int         UNLOCK_CYCLES  = 8;
    localparam int         LOCKOUT_CYCLES = 32;
    localparam int         TIMEOUT_CYCLES = 16;

    logic       clk       = 1'b0;
    logic       clear     = 1'b1;
    logic       b_valid   = 1'b0;
    logic       b_in      = 1'b0;
    logic       prog_req  = 1'b0;
    logic [5:0] prog_code = 6'd0;
    logic       unlock, locked_out, attempt_fail, prog_ack, prog_nack, busy;
    logic [3:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    lock_sequencer #(
        .CODE_W        (CODE_W),
        .DEFAULT_CODE  (DEF),
        .MAX_FAILS     (MAX_FAILS),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .b_valid     (b_valid),
        .b_in        (b_in),
        .prog_req    (prog_req),
        .prog_code   (prog_code),
        .unlock      (unlock),
        .locked_out  (locked_out),
        .attempt_fail(attempt_fail),
        .prog_ack    (prog_ack),
        .prog_nack   (prog_nack),
        .fail_cnt    (fail_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: collected bits in a queue, open/lockout as remaining-cycle counts
    int         q[$];
    int         gap = 0, open_left = 0, lock_left = 0, fails = 0, val = 0;
    bit         pend = 1'b0;
    logic [5:0] mcode = DEF;
    logic       e_unlock = 0, e_lo = 0, e_fail = 0, e_ack = 0, e_nack = 0, e_busy = 0;
    int         e_fcnt = 0;

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            q.delete();
            gap = 0; open_left = 0; lock_left = 0; fails = 0; pend = 1'b0;
            mcode = DEF;
            e_unlock = 0; e_lo = 0; e_fail = 0; e_ack = 0; e_nack = 0; e_busy = 0;
            e_fcnt = 0;
        end else begin
            e_fail = 1'b0;
            e_ack  = prog_req && (open_left > 0);
            e_nack = prog_req && (open_left == 0);
            if (pend) begin
                val = 0;
                foreach (q[i]) val += q[i] << i;
                if (val == int'(mcode)) begin
                    open_left = UNLOCK_CYCLES;
                    fails = 0;
                end else begin
                    fails++;
                    e_fail = 1'b1;
                    if (fails == MAX_FAILS) lock_left = LOCKOUT_CYCLES;
                end
                q.delete();
                pend = 1'b0;
            end else if (open_left > 0) begin
                open_left--;
            end else if (lock_left > 0) begin
                lock_left--;
                if (lock_left == 0) fails = 0;
            end else if (b_valid) begin
                q.push_back(int'(b_in));
                gap = 0;
                if (q.size() == CODE_W) pend = 1'b1;
            end else if (q.size() > 0) begin
                gap++;
                if (gap == TIMEOUT_CYCLES) begin
                    q.delete();
                    gap = 0;
                end
            end
            if (e_ack) mcode = prog_code;
            e_unlock = (open_left > 0);
            e_lo     = (lock_left > 0);
            e_busy   = (q.size() > 0);
            e_fcnt   = fails;
        end
    end

    int unl_total = 0, lo_total = 0;
    always @(posedge clk) begin
        if (unlock === 1'b1) unl_total++;
        if (locked_out === 1'b1) lo_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bits(input logic [5:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_in    = c[i];
        end
        @(negedge clk);
        b_valid = 1'b0;
        b_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, l0;
        fork
            forever begin
                @(negedge clk);
                chk("cyc_unlock", unlock, e_unlock);
                chk("cyc_locked_out", locked_out, e_lo);
                chk("cyc_attempt_fail", attempt_fail, e_fail);
                chk("cyc_prog_ack", prog_ack, e_ack);
                chk("cyc_prog_nack", prog_nack, e_nack);
                chk("cyc_busy", busy, e_busy);
                chk("cyc_fail_cnt", fail_cnt, e_fcnt);
            end
            begin
                #1 clear = 1'b0;
                idle(3);
                chk("rst_unlock", unlock, 0);
                chk("rst_fail_cnt", fail_cnt, 0);
                chk("rst_busy", busy, 0);
                clear = 1'b1;
                @(negedge clk);

                // correct default code opens for exactly 8 cycles
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t1_unlock", unlock, 1);
                chk("t1_fail_cnt", fail_cnt, 0);
                u0 = unl_total;
                idle(12);
                chk("t1_open_len", unl_total - u0, UNLOCK_CYCLES);

                // three failures -> lockout that ignores a correct code
                for (int k = 1; k <= 3; k++) begin
                    send_bits(6'h3F, 6);
                    @(negedge clk);
                    chk("t2_attempt_fail", attempt_fail, 1);
                    chk("t2_fail_cnt", fail_cnt, k);
                end
                chk("t2_locked_out", locked_out, 1);
                l0 = lo_total;
                u0 = unl_total;
                send_bits(DEF, 6);
                idle(40);
                chk("t2_lockout_len", lo_total - l0, LOCKOUT_CYCLES);
                chk("t2_no_unlock", unl_total - u0, 0);
                chk("t2_fail_cnt_clr", fail_cnt, 0);

                // two failures then success clears the count
                send_bits(6'h00, 6);
                @(negedge clk);
                send_bits(6'h00, 6);
                @(negedge clk);
                chk("t3_fail_cnt", fail_cnt, 2);
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t3_unlock", unlock, 1);
                chk("t3_fail_cnt_clr", fail_cnt, 0);
                idle(10);

                // reprogramming while open
                send_bits(DEF, 6);
                @(negedge clk);
                prog_req = 1'b1; prog_code = NEW_CODE;
                @(negedge clk);
                prog_req = 1'b0;
                chk("t4_prog_ack", prog_ack, 1);
                chk("t4_prog_nack", prog_nack, 0);
                idle(10);
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t4_old_code_fail", attempt_fail, 1);
                chk("t4_old_code_locked", unlock, 0);
                send_bits(NEW_CODE, 6);
                @(negedge clk);
                chk("t4_new_unlock", unlock, 1);
                chk("t4_new_fail_cnt", fail_cnt, 0);
                idle(7);
                prog_req = 1'b1; prog_code = DEF;
                @(negedge clk);
                prog_req = 1'b0;
                chk("t4_last_open_ack", prog_ack, 1);
                chk("t4_closed", unlock, 0);
                idle(2);
                prog_req = 1'b1; prog_code = 6'h3F;
                @(negedge clk);
                chk("t4_idle_nack", prog_nack, 1);
                @(negedge clk);
                chk("t4_held_nack", prog_nack, 1);
                prog_req = 1'b0;
                @(negedge clk);
                chk("t4_nack_drop", prog_nack, 0);
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t4_code_kept", unlock, 1);
                idle(10);

                // idle gap aborts a partial attempt without counting a failure
                send_bits(DEF, 3);
                idle(15);
                chk("t5_busy_hold", busy, 1);
                idle(1);
                chk("t5_timeout_idle", busy, 0);
                chk("t5_no_fail", fail_cnt, 0);
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t5_unlock", unlock, 1);
                idle(10);

                // reset mid-attempt
                send_bits(DEF, 4);
                clear = 1'b0;
                @(negedge clk);
                chk("t6_rst_busy", busy, 0);
                chk("t6_rst_unlock", unlock, 0);
                idle(2);
                clear = 1'b1;
                send_bits(DEF, 6);
                @(negedge clk);
                chk("t6_unlock", unlock, 1);
                idle(10);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
